// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver (8E1 with UART_RX_PARITY_EN); 2-flop sync, bits sampled at mid-bit.
// Latency 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk from start edge; no backpressure, data overwritten.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic             sync1_q;
    logic             rx_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             armed_q, armed_d;
    logic [7:0]       data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             parity_err_q, parity_err_d;
`endif
    logic             bit_done;

    assign bit_done = (cnt_q == FULL_M1);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            armed_q      <= 1'b1;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q      <= rxd;
            rx_s_q       <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            armed_q      <= armed_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        armed_d      = armed_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // After a break the line must go high once before a new start edge counts
                if (!armed_q) begin
                    if (rx_s_q) armed_d = 1'b1;
                end else if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                // Leave at the stop midpoint so a back-to-back start edge is caught in time
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (^{shift_q, par_q}) begin
                        parity_err_d = 1'b1;
                    end
`endif
                    else begin
                        data_valid_d = 1'b1;
                        data_d       = shift_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        data       = data_q;
        data_valid = data_valid_q;
        frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
        parity_err = parity_err_q;
`else
        parity_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clk/bit: frame-level reference model schedules expected strobes.
// One compare process checks strobes and held data every cycle against that schedule.
module tb_uart_rx;

    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LAT = 2 + C / 2 + (NBITS - 1) * C + 1;
    localparam int K_DV = 1;
    localparam int K_FE = 2;
    localparam int K_PE = 3;

    typedef struct {
        int         t;
        int         kind;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int         edge_n = 0;
    int         checks = 0;
    int         failures = 0;
    bit         chk_en = 1'b0;
    logic [7:0] model_data = 8'h00;
    ev_t        evq[$];
    int         dv_times[$];
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    ev_t        cur_ev;
    logic [2:0] exp_s;

    uart_rx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, edge_n);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            exp_s = 3'b000;
            if (evq.size() > 0 && evq[0].t == edge_n) begin
                cur_ev = evq.pop_front();
                case (cur_ev.kind)
                    K_DV: begin
                        exp_s      = 3'b100;
                        model_data = cur_ev.b;
                    end
                    K_FE:    exp_s = 3'b010;
                    default: exp_s = 3'b001;
                endcase
            end
            chk("strobes", {data_valid, frame_err, parity_err}, exp_s);
            chk("data", data, model_data);
            if (data_valid) dv_times.push_back(edge_n);
            if (frame_err) fe_cnt++;
            if (parity_err) pe_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int n, input bit chk_idle);
        for (int i = 0; i < n; i++) begin
            rxd = v;
            if (chk_idle) chk("busy_idle", busy, 1'b0);
            step();
        end
    endtask

    // Drives one frame; rst_k >= 0 pulses reset at that cycle of the frame and abandons it.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v,
                              input int rst_k, output int t0);
        logic [NBITS-1:0] bits;
        ev_t ev;
        bits = '0;
        for (int i = 0; i < 8; i++) bits[1+i] = b[i];
        if (NBITS == 11) bits[9] = par_v;
        bits[NBITS-1] = stop_v;
        t0   = edge_n;
        ev.t = t0 + LAT;
        ev.b = b;
        if (!stop_v) ev.kind = K_FE;
        else if (NBITS == 11 && ((^b) ^ par_v)) ev.kind = K_PE;
        else ev.kind = K_DV;
        evq.push_back(ev);
        for (int k = 0; k < NBITS * C; k++) begin
            if (k == rst_k) begin
                reset = 1'b1;
                rxd   = 1'b1;
                evq.delete();
                model_data = 8'h00;
                step();
                reset = 1'b0;
                return;
            end
            rxd = bits[k/C];
            if (k >= 3 && k <= LAT - 1) chk("busy_in_frame", busy, 1'b1);
            step();
        end
    endtask

    initial begin
        int t0;
        int ta;
        int tb;
        int n0;
        int f0;
        logic [7:0] rb;
        logic       rstop;
        int         gap;
        bit         prev_bad;

        rxd   = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_fe", frame_err, 1'b0);
        chk("rst_pe", parity_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        hold(1'b1, 20, 1'b1);

        // Single frame, latency pinned by literal
        n0 = dv_times.size();
        send_frame(8'hA5, 1'b1, ^8'hA5, -1, t0);
        hold(1'b1, 20, 1'b0);
        chk("a5_count", dv_times.size() - n0, 1);
        if (dv_times.size() > n0) chk("a5_latency", dv_times[n0] - t0, (NBITS == 11) ? 171 : 155);
        chk("a5_data", data, 8'hA5);

        // Back-to-back, no idle gap
        n0 = dv_times.size();
        f0 = fe_cnt;
        send_frame(8'h00, 1'b1, 1'b0, -1, t0);
        send_frame(8'hFF, 1'b1, 1'b0, -1, ta);
        send_frame(8'h3C, 1'b1, 1'b0, -1, tb);
        hold(1'b1, 20, 1'b0);
        chk("b2b_count", dv_times.size() - n0, 3);
        if (dv_times.size() >= n0 + 3) begin
            chk("b2b_gap1", dv_times[n0+1] - dv_times[n0], (NBITS == 11) ? 176 : 160);
            chk("b2b_gap2", dv_times[n0+2] - dv_times[n0+1], (NBITS == 11) ? 176 : 160);
        end
        chk("b2b_data", data, 8'h3C);
        chk("b2b_no_fe", fe_cnt - f0, 0);

        // Short glitch on the line
        for (int k = 0; k < 16; k++) begin
            rxd = (k < 4) ? 1'b0 : 1'b1;
            if (k == 4) chk("glitch_busy_hi", busy, 1'b1);
            if (k == 11) chk("glitch_busy_lo", busy, 1'b0);
            step();
        end
        hold(1'b1, 20, 1'b1);

        // Bad stop bit followed by a held break
        f0 = fe_cnt;
        send_frame(8'h5A, 1'b0, ^8'h5A, -1, t0);
        hold(1'b0, 3 * C, 1'b1);
        chk("fe_count", fe_cnt - f0, 1);
        chk("fe_data_kept", data, 8'h3C);
        hold(1'b1, C, 1'b1);
        send_frame(8'h81, 1'b1, ^8'h81, -1, t0);
        hold(1'b1, 20, 1'b0);
        chk("after_break_data", data, 8'h81);

        // Reset in the middle of data bit 4
        n0 = dv_times.size();
        send_frame(8'hC3, 1'b1, ^8'hC3, 5 * C + 8, t0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_data", data, 8'h00);
        chk("midrst_strobes", {data_valid, frame_err, parity_err}, 3'b000);
        hold(1'b1, 2 * C, 1'b1);
        chk("midrst_no_dv", dv_times.size() - n0, 0);
        send_frame(8'h7E, 1'b1, ^8'h7E, -1, t0);
        hold(1'b1, 20, 1'b0);
        chk("after_rst_data", data, 8'h7E);

`ifdef UART_RX_PARITY_EN
        f0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1, -1, t0);
        hold(1'b1, 20, 1'b0);
        chk("par_good_data", data, 8'h07);
        send_frame(8'h07, 1'b1, 1'b0, -1, t0);
        hold(1'b1, 20, 1'b0);
        chk("par_bad_count", pe_cnt - f0, 1);
        chk("par_bad_data", data, 8'h07);
`endif

        // Randomized frames, gaps and bad stop bits
        prev_bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 7) != 0);
            gap   = $urandom_range(0, 30);
            if (gap < 4 && prev_bad) gap = 4;
            if ($urandom_range(0, 2) == 0 && !prev_bad) gap = 0;
            hold(1'b1, gap, 1'b0);
            send_frame(rb, rstop, (NBITS == 11) ? 1'($urandom_range(0, 1)) : ^rb, -1, t0);
            prev_bad = !rstop;
        end
        hold(1'b1, LAT + 20, 1'b0);
        chk("queue_drained", evq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
